vga_pixel_sink: RTL

VGA_PIXEL_SINK -- requirements
Module: vga_pixel_sink

---
 rtl/vga_pixel_sink.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/vga_pixel_sink.sv
// rtl/vga_pixel_sink.sv - 3-bit framebuffer sink with full-raster readback scan
// Optional FB_CLEAR_EN: zero the whole framebuffer after every reset.
module vga_pixel_sink #(
  parameter int FB_W = 160,
  parameter int FB_H = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  vga_x,
  input  logic [6:0]  vga_y,
  input  logic [2:0]  vga_colour,
  input  logic        vga_plot,
  output logic        ready,
  input  logic        scan_start,
  output logic        rd_valid,
  output logic [7:0]  rd_x,
  output logic [6:0]  rd_y,
  output logic [2:0]  rd_colour,
  output logic        scan_done,
  output logic [14:0] pixel_count,
  output logic [7:0]  oob_count
);
  localparam int DEPTH = FB_W * FB_H;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [8:0]    X_LIM     = 9'(FB_W);
  localparam logic [7:0]    Y_LIM     = 8'(FB_H);
  localparam logic [7:0]    X_LAST    = 8'(FB_W - 1);
  localparam logic [6:0]    Y_LAST    = 7'(FB_H - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ROW_STEP  = AW'(FB_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
`ifdef FB_CLEAR_EN
    , S_CLEAR = 2'd3
`endif
  } state_t;

`ifdef FB_CLEAR_EN
  localparam state_t RST_STATE = S_CLEAR;
`else
  localparam state_t RST_STATE = S_IDLE;
`endif

  state_t state_q, state_d;

  logic [2:0]    mem [DEPTH];
  logic [7:0]    rp_x_q;
  logic [6:0]    rp_y_q;
  logic [AW-1:0] rp_addr_q;
  logic          rd_valid_q, scan_done_q;
  logic [7:0]    rd_x_q;
  logic [6:0]    rd_y_q;
  logic [2:0]    rd_colour_q;
  logic [14:0]   pix_q;
  logic [7:0]    oob_q;

  logic          in_range, plot_acc, plot_wr, plot_oob;
  logic          rd_issue, clr_we, rp_last;
  logic [AW-1:0] wr_addr;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [2:0]    mem_wdata;

`ifdef FB_CLEAR_EN
  assign ready = ~rst & (state_q != S_CLEAR);
`else
  assign ready = ~rst;
`endif

  assign in_range = ({1'b0, vga_x} < X_LIM) && ({1'b0, vga_y} < Y_LIM);
  assign plot_acc = vga_plot & ready;
  assign plot_wr  = plot_acc & in_range;
  assign plot_oob = plot_acc & ~in_range;
  assign wr_addr  = AW'(vga_y) * ROW_STEP + AW'(vga_x);
  assign rp_last  = (rp_x_q == X_LAST) && (rp_y_q == Y_LAST);

  // Writes win the RAM port; the scan simply waits a cycle.
  always_comb begin
    state_d  = state_q;
    rd_issue = 1'b0;
    clr_we   = 1'b0;
    case (state_q)
      S_IDLE: if (scan_start) state_d = S_SCAN;
      S_SCAN: begin
        if (!plot_wr) begin
          rd_issue = 1'b1;
          if (rp_last) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
`ifdef FB_CLEAR_EN
      S_CLEAR: begin
        clr_we = 1'b1;
        if (rp_addr_q == ADDR_LAST) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_we    = plot_wr | clr_we;
    mem_waddr = clr_we ? rp_addr_q : wr_addr;
    mem_wdata = clr_we ? 3'd0 : vga_colour;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RST_STATE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rp_x_q      <= '0;
      rp_y_q      <= '0;
      rp_addr_q   <= '0;
      rd_valid_q  <= 1'b0;
      scan_done_q <= 1'b0;
      rd_x_q      <= '0;
      rd_y_q      <= '0;
      rd_colour_q <= '0;
      pix_q       <= '0;
      oob_q       <= '0;
    end else begin
      rd_valid_q  <= rd_issue;
      scan_done_q <= (state_q == S_DONE);
      if (state_q == S_IDLE && scan_start) begin
        rp_x_q    <= '0;
        rp_y_q    <= '0;
        rp_addr_q <= '0;
      end else if (rd_issue) begin
        rd_x_q      <= rp_x_q;
        rd_y_q      <= rp_y_q;
        rd_colour_q <= mem[rp_addr_q];
        rp_addr_q   <= rp_addr_q + AW'(1);
        if (rp_x_q == X_LAST) begin
          rp_x_q <= '0;
          rp_y_q <= rp_y_q + 7'd1;
        end else begin
          rp_x_q <= rp_x_q + 8'd1;
        end
      end else if (clr_we) begin
        rp_addr_q <= (rp_addr_q == ADDR_LAST) ? '0 : rp_addr_q + AW'(1);
      end
      if (plot_wr && pix_q != 15'h7fff) pix_q <= pix_q + 15'd1;
      if (plot_oob && oob_q != 8'hff)   oob_q <= oob_q + 8'd1;
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_x        = rd_x_q;
  assign rd_y        = rd_y_q;
  assign rd_colour   = rd_colour_q;
  assign scan_done   = scan_done_q;
  assign pixel_count = pix_q;
  assign oob_count   = oob_q;

endmodule
